// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared state/direction encodings and playfield geometry for the pong controller
package pong_pkg;

  localparam int H_VISIBLE     = 400;
  localparam int V_VISIBLE     = 600;
  localparam int PADDLE_H      = 100;
  localparam int L_PADDLE_XMAX = 20;
  localparam int R_PADDLE_XMIN = 380;
  localparam int BALL_SIZE     = 8;
  localparam int BALL_STEP     = 2;
  localparam int PADDLE_STEP   = 4;

  // 10-bit forms of the geometry, so position arithmetic stays at coordinate width
  localparam logic [9:0] PADDLE_H_V    = 10'(PADDLE_H);
  localparam logic [9:0] BALL_SIZE_V   = 10'(BALL_SIZE);
  localparam logic [9:0] BALL_STEP_V   = 10'(BALL_STEP);
  localparam logic [9:0] PADDLE_STEP_V = 10'(PADDLE_STEP);
  localparam logic [9:0] PADDLE_Y_MAX  = 10'(V_VISIBLE - PADDLE_H);
  localparam logic [9:0] PADDLE_Y_CTR  = 10'((V_VISIBLE - PADDLE_H) / 2);
  localparam logic [9:0] BALL_X_CTR    = 10'((H_VISIBLE - BALL_SIZE) / 2);
  localparam logic [9:0] BALL_Y_CTR    = 10'((V_VISIBLE - BALL_SIZE) / 2);
  localparam logic [9:0] BALL_Y_MAX    = 10'(V_VISIBLE - BALL_SIZE);
  localparam logic [9:0] BALL_X_LHIT   = 10'(L_PADDLE_XMAX);
  localparam logic [9:0] BALL_X_RHIT   = 10'(R_PADDLE_XMIN - BALL_SIZE);
  localparam logic [9:0] R_PADDLE_X_V  = 10'(R_PADDLE_XMIN);
  localparam logic [9:0] H_VISIBLE_V   = 10'(H_VISIBLE);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_t;

  function automatic logic overlap(input logic [9:0] by, input logic [9:0] py);
    return ((by + BALL_SIZE_V) > py) && (by < (py + PADDLE_H_V));
  endfunction

endpackage

// File: rtl/pong_paddle.sv
// rtl/pong_paddle.sv - one paddle's top line, stepping per frame and clamped to the playfield
module pong_paddle
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tick,
  input  logic       i_freeze,
  input  logic       i_up,
  input  logic       i_dn,
  output logic [9:0] o_y
);

  logic [9:0] r_y;

  // Both or neither key held means no movement
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_y <= PADDLE_Y_CTR;
    end else if (i_tick && !i_freeze && (i_up ^ i_dn)) begin
      if (i_up) begin
        r_y <= (r_y < PADDLE_STEP_V) ? 10'd0 : (r_y - PADDLE_STEP_V);
      end else begin
        r_y <= (r_y > (PADDLE_Y_MAX - PADDLE_STEP_V)) ? PADDLE_Y_MAX : (r_y + PADDLE_STEP_V);
      end
    end
  end

  assign o_y = r_y;

endmodule

// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - pong match sequencer: serve timing, ball flight, paddle hits and scoring
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       l_up,
  input  logic       l_dn,
  input  logic       r_up,
  input  logic       r_dn,
  output logic [9:0] p1_y,
  output logic [9:0] p2_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [2:0] state,
  output logic       winner
);

  localparam int              CW         = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
  localparam logic [CW-1:0]   SERVE_LAST = CW'(SERVE_FRAMES - 1);
  localparam logic [3:0]      WIN_S      = 4'(WIN_SCORE);

  state_t        r_state;
  logic [9:0]    r_bx, r_by;
  dir_t          r_dx, r_dy;
  logic [3:0]    r_sl, r_sr;
  logic          r_winner, r_scorer;
  logic [CW-1:0] r_cnt;

  logic       w_move;
  logic [9:0] w_p1_y, w_p2_y, w_nx, w_ny;
  dir_t       w_dx, w_dy;
  logic       w_pt_l, w_pt_r;
  logic [3:0] w_new_score;

  assign w_move      = (r_state == ST_SERVE) || (r_state == ST_PLAY);
  assign w_new_score = (r_scorer ? r_sr : r_sl) + 4'd1;

  pong_paddle u_p1 (
    .clk(clk), .rst(rst), .i_tick(frame_tick), .i_freeze(!w_move),
    .i_up(l_up), .i_dn(l_dn), .o_y(w_p1_y)
  );

  pong_paddle u_p2 (
    .clk(clk), .rst(rst), .i_tick(frame_tick), .i_freeze(!w_move),
    .i_up(r_up), .i_dn(r_dn), .o_y(w_p2_y)
  );

  // Next ball position; hit tests see the paddles before this frame's move
  always_comb begin
    w_ny   = r_by;
    w_dy   = r_dy;
    w_nx   = r_bx;
    w_dx   = r_dx;
    w_pt_l = 1'b0;
    w_pt_r = 1'b0;

    if (r_dy == DIR_NEG) begin
      if (r_by <= BALL_STEP_V) begin
        w_ny = 10'd0;
        w_dy = DIR_POS;
      end else begin
        w_ny = r_by - BALL_STEP_V;
      end
    end else if ((r_by + BALL_STEP_V) >= BALL_Y_MAX) begin
      w_ny = BALL_Y_MAX;
      w_dy = DIR_NEG;
    end else begin
      w_ny = r_by + BALL_STEP_V;
    end

    if (r_dx == DIR_NEG) begin
      if ((r_bx <= (BALL_X_LHIT + BALL_STEP_V)) && overlap(r_by, w_p1_y)) begin
        w_nx = BALL_X_LHIT;
        w_dx = DIR_POS;
      end else if (r_bx < BALL_STEP_V) begin
        w_pt_r = 1'b1;
      end else begin
        w_nx = r_bx - BALL_STEP_V;
      end
    end else begin
      if (((r_bx + BALL_STEP_V + BALL_SIZE_V) >= R_PADDLE_X_V) && overlap(r_by, w_p2_y)) begin
        w_nx = BALL_X_RHIT;
        w_dx = DIR_NEG;
      end else if ((r_bx + BALL_STEP_V + BALL_SIZE_V) >= H_VISIBLE_V) begin
        w_pt_l = 1'b1;
      end else begin
        w_nx = r_bx + BALL_STEP_V;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_bx     <= BALL_X_CTR;
      r_by     <= BALL_Y_CTR;
      r_dx     <= DIR_POS;
      r_dy     <= DIR_POS;
      r_sl     <= 4'd0;
      r_sr     <= 4'd0;
      r_winner <= 1'b0;
      r_scorer <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_SERVE;
            r_cnt   <= '0;
          end
        end
        ST_SERVE: begin
          if (frame_tick) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == SERVE_LAST) r_state <= ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (frame_tick) begin
            if (w_pt_l || w_pt_r) begin
              r_scorer <= w_pt_r;
              r_state  <= ST_POINT;
            end else begin
              r_bx <= w_nx;
              r_by <= w_ny;
              r_dx <= w_dx;
              r_dy <= w_dy;
            end
          end
        end
        ST_POINT: begin
          if (r_scorer) r_sr <= w_new_score;
          else          r_sl <= w_new_score;
          if (w_new_score == WIN_S) begin
            r_state  <= ST_OVER;
            r_winner <= r_scorer;
          end else begin
            // Serve toward whoever just conceded
            r_state <= ST_SERVE;
            r_bx    <= BALL_X_CTR;
            r_by    <= BALL_Y_CTR;
            r_cnt   <= '0;
            r_dx    <= r_scorer ? DIR_NEG : DIR_POS;
            r_dy    <= DIR_POS;
          end
        end
        ST_OVER: begin
          if (start) begin
            r_state <= ST_SERVE;
            r_sl    <= 4'd0;
            r_sr    <= 4'd0;
            r_bx    <= BALL_X_CTR;
            r_by    <= BALL_Y_CTR;
            r_dx    <= DIR_POS;
            r_dy    <= DIR_POS;
            r_cnt   <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign p1_y    = w_p1_y;
  assign p2_y    = w_p2_y;
  assign ball_x  = r_bx;
  assign ball_y  = r_by;
  assign score_l = r_sl;
  assign score_r = r_sr;
  assign state   = r_state;
  assign winner  = r_winner;

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Game-sequencing controller for the pong design. It owns paddle positions, ball position and direction, scores and the match state machine. All motion advances once per video frame on `frame_tick`. Outputs drive the sprite-coordinate inputs of pong_vga and the 4-bit score inputs of the two pong_score instances.

Parameters:
H_VISIBLE, 400, visible pixels per line (20 MHz pixel clock)
V_VISIBLE, 600, visible lines
PADDLE_H, 100, paddle height in lines
L_PADDLE_XMAX, 20, right edge of left paddle (left paddle spans x 10..20)
R_PADDLE_XMIN, 380, left edge of right paddle (right paddle spans x 380..390)
BALL_SIZE, 8, ball square side in pixels
BALL_STEP, 2, ball pixels per frame per axis
PADDLE_STEP, 4, paddle lines per frame
SERVE_FRAMES, 60, frames the ball rests centred before play
WIN_SCORE, 9, points to win; must be ≤ 9

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  reset, asynchronous, active-low
frame_tick  in  1  one-cycle pulse at start of vertical blanking
start  in  1  one-cycle pulse: begin match / restart after game over
l_up  in  1  left paddle up, level
l_dn  in  1  left paddle down, level
r_up  in  1  right paddle up, level
r_dn  in  1  right paddle down, level
p1_y  out  10  left paddle top line
p2_y  out  10  right paddle top line
ball_x  out  10  ball left pixel
ball_y  out  10  ball top line
score_l  out  4  left score
score_r  out  4  right score
state  out  3  IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4
winner  out  1  0 = left, 1 = right; valid in OVER

Behaviour:
- Reset (rst low, asynchronous): p1_y = p2_y = (V_VISIBLE-PADDLE_H)/2 = 250; ball_x = (H_VISIBLE-BALL_SIZE)/2 = 196; ball_y = (V_VISIBLE-BALL_SIZE)/2 = 296; dx = +1, dy = +1; scores 0; serve counter 0; winner 0; state IDLE.
- All registers update on the rising clk edge. Output latency is 1 cycle after `frame_tick`.
- IDLE: positions frozen. `start` → SERVE with counter = 0. If `start` and `frame_tick` arrive in the same cycle, no motion occurs that cycle.
- SERVE: ball held at centre. Paddles move. Each `frame_tick` increments the counter. On the tick where counter = SERVE_FRAMES-1, go to PLAY.
- PLAY: on each `frame_tick`, paddles and ball update in the same cycle. Hit tests use the pre-update paddle positions.
- Paddle update, identical for both paddles:
  - up only: y = max(y-PADDLE_STEP, 0)
  - down only: y = min(y+PADDLE_STEP, V_VISIBLE-PADDLE_H = 500)
  - both or neither: hold
  - Saturating arithmetic; no wrap.
- Ball y: ny = y ± BALL_STEP.
  - If ny ≤ 0 (underflow included): ny = 0, dy = +1.
  - If ny ≥ V_VISIBLE-BALL_SIZE: ny = 592, dy = -1.
- Vertical overlap with a paddle at top py: ball_y+BALL_SIZE > py AND ball_y < py+PADDLE_H.
- Ball x, moving left: nx = x-BALL_STEP.
  - If nx ≤ L_PADDLE_XMAX and overlap(p1_y): nx = 20, dx = +1.
  - Else if x < BALL_STEP: right scores.
- Ball x, moving right: nx = x+BALL_STEP.
  - If nx+BALL_SIZE ≥ R_PADDLE_XMIN and overlap(p2_y): nx = 372, dx = -1.
  - Else if nx+BALL_SIZE ≥ H_VISIBLE: left scores.
- Scoring: the ball does not move; go to POINT.
- POINT (1 cycle, independent of `frame_tick`):
  - Increment the scorer's score.
  - If the new score = WIN_SCORE: go to OVER, winner = scorer.
  - Else: go to SERVE, ball centred, counter 0, dx toward the conceding player, dy = +1.
- OVER: all motion frozen; outputs held. `start` → scores 0, ball centred, dx = +1, SERVE.
- `start` is ignored in SERVE, PLAY and POINT.
- Reset asserted mid-operation forces the reset values immediately.

Decomposition:
- pong_pkg holds:
  - state encoding
  - geometry constants: centre values, paddle/ball limits
  - direction encoding
- Sub-module pong_paddle: clamped up/down position register with frame_tick enable and freeze input, instantiated twice.

Test Plan:
- Reset: drive rst low mid-PLAY → p1_y = p2_y = 250, ball (196,296), scores 0, state 0. Ten frame_ticks in IDLE → no change.
- Paddle: SERVE_FRAMES=60, in SERVE hold l_up 10 ticks → p1_y = 210. Hold 100 more → 0. Press l_up+l_dn → held. Hold r_dn 200 ticks → p2_y = 500.
- Serve timing: SERVE_FRAMES=2, start pulse → state PLAY after 2nd tick. 1st PLAY tick → ball (198,298).
- Paddle hit: SERVE_FRAMES=2, r_dn held for the first 43 PLAY ticks → p2_y = 422. PLAY tick 88 → ball_x = 372, ball_y = 472. Tick 89 → ball_x = 370.
- Miss: SERVE_FRAMES=2, p2_y driven to 0 → at PLAY tick 98 → state POINT, then score_l = 1, state SERVE, ball (196,296), dx = +1.
- Game over: WIN_SCORE=2, two left scores → state OVER, winner = 0, frame_ticks ignored. `start` → scores 0, state SERVE.
